// File: rtl/uart_tx_arb_if.sv
// Requester and transmitter-side signal bundle for the UART line arbiter.
// slave is the arbiter's view; master is the view of the requesters and transmitter.
interface uart_tx_arb_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic        line_active;

    modport master (
        output req_valid, req_data, tx_ready,
        input  req_ready, tx_valid, tx_data, grant_id, line_active
    );

    modport slave (
        input  req_valid, req_data, tx_ready,
        output req_ready, tx_valid, tx_data, grant_id, line_active
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Line-granular round-robin arbiter sharing one UART transmitter among four byte requesters.
// An owner keeps the transmitter until LF, MAX_LINE bytes, or IDLE_TO idle cycles.
module uart_tx_arb #(
    parameter int unsigned MAX_LINE = 32,
    parameter int unsigned IDLE_TO  = 1024
) (
    input logic          clk,
    input logic          rst_n,
    uart_tx_arb_if.slave bus
);
    localparam int unsigned IdleW = $clog2(IDLE_TO + 1);

    typedef enum logic {StIdle, StLock} state_e;

    state_e           state_q, state_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       last_q, last_d;
    logic [7:0]       line_cnt_q, line_cnt_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

    logic [1:0] rr_idx, rr_pick;
    logic       rr_found;
    logic       owner_valid, accept, rel;
    logic [7:0] owner_byte;

    // First valid requester searching upward from last_owner + 1.
    always_comb begin
        rr_pick  = 2'd0;
        rr_found = 1'b0;
        rr_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            rr_idx = 2'(int'(last_q) + k);
            if (!rr_found && bus.req_valid[rr_idx]) begin
                rr_pick  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    assign owner_valid = bus.req_valid[grant_q];
    assign owner_byte  = bus.req_data[{grant_q, 3'b000} +: 8];

    // Ready also gated by rst_n so nothing is accepted while reset is asserted.
    always_comb begin
        bus.req_ready = 4'b0000;
        if (rst_n && state_q == StLock && (!tx_valid_q || bus.tx_ready)) begin
            bus.req_ready[grant_q] = 1'b1;
        end
    end

    assign accept = |(bus.req_ready & bus.req_valid);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        line_cnt_d = line_cnt_q;
        idle_cnt_d = idle_cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rel        = 1'b0;

        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = owner_byte;
        end else if (bus.tx_ready) begin
            tx_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (rr_found) begin
                    state_d    = StLock;
                    grant_d    = rr_pick;
                    line_cnt_d = 8'd0;
                    idle_cnt_d = '0;
                end
            end
            StLock: begin
                if (accept) begin
                    line_cnt_d = line_cnt_q + 8'd1;
                    if (owner_byte == 8'h0A || line_cnt_q == 8'(MAX_LINE - 1)) begin
                        rel = 1'b1;
                    end
                end
                if (owner_valid) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                    if (idle_cnt_q == IdleW'(IDLE_TO - 1)) begin
                        rel = 1'b1;
                    end
                end
                if (rel) begin
                    state_d = StIdle;
                    last_d  = grant_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            grant_q    <= 2'd0;
            last_q     <= 2'd3;
            line_cnt_q <= 8'd0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            line_cnt_q <= line_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign bus.tx_valid    = tx_valid_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_id    = grant_q;
    assign bus.line_active = (state_q == StLock);
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed line scenarios plus random traffic, checked against a
// line-level model that predicts the byte/owner stream from the requester queues.
module tb_uart_tx_arb;
    localparam int unsigned MaxLine = 32;
    localparam int unsigned IdleTo  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arb_if bus ();

    uart_tx_arb #(
        .MAX_LINE(MaxLine),
        .IDLE_TO (IdleTo)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors;
    int miscompares;

    logic [7:0] qmem [4][64];
    int         qhead[4];
    int         qtail[4];

    logic [7:0] ebyte[1024];
    logic [1:0] eown [1024];
    int         n_exp, acc_idx, xfer_idx;
    int         mdl_last;

    int         force_rdy;
    int         step_no;
    logic       obs_la, obs_tv, obs_xfer;
    logic [1:0] obs_gid;
    logic [7:0] obs_td;
    logic [3:0] obs_ready, obs_acc;
    logic       prev_hold, prev_acc, prev_la;
    logic [7:0] prev_td, prev_byte;

    int line_own[64];
    int line_len[64];
    int line_end[64];
    int n_lines;
    int last_acc_step[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, step_no);
        end
    endtask

    task automatic push(input int r, input logic [7:0] b);
        qmem[r][qtail[r]] = b;
        qtail[r]++;
    endtask

    task automatic push_str(input int r, input string s);
        for (int i = 0; i < s.len(); i++) push(r, s[i]);
    endtask

    function automatic bit pending();
        for (int r = 0; r < 4; r++) if (qhead[r] < qtail[r]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic new_test();
        for (int r = 0; r < 4; r++) begin
            qhead[r] = 0;
            qtail[r] = 0;
        end
        n_lines = 0;
    endtask

    // Line-level model: round-robin over non-empty queues, a line ends at LF, MaxLine bytes
    // or when the owner's queue runs dry (the idle timeout then releases it).
    task automatic build_expected();
        int h[4];
        int cur, cnt, r;
        logic [7:0] b;
        n_exp    = 0;
        acc_idx  = 0;
        xfer_idx = 0;
        for (int i = 0; i < 4; i++) h[i] = qhead[i];
        forever begin
            cur = -1;
            for (int k = 1; k <= 4; k++) begin
                r = (mdl_last + k) % 4;
                if (cur < 0 && h[r] < qtail[r]) cur = r;
            end
            if (cur < 0) break;
            cnt = 0;
            while (h[cur] < qtail[cur]) begin
                b = qmem[cur][h[cur]];
                h[cur]++;
                ebyte[n_exp] = b;
                eown[n_exp]  = 2'(cur);
                n_exp++;
                cnt++;
                if (b == 8'h0A || cnt == int'(MaxLine)) break;
            end
            mdl_last = cur;
        end
    endtask

    // One clock cycle: drive after the falling edge, observe 1 time unit later, and account
    // for the handshakes that the next rising edge will complete.
    task automatic step();
        logic [3:0] exp_rdy;
        logic [7:0] d;
        for (int r = 0; r < 4; r++) begin
            bus.req_valid[r]       = (qhead[r] < qtail[r]);
            bus.req_data[8*r +: 8] = (qhead[r] < qtail[r]) ? qmem[r][qhead[r]] : 8'($urandom);
        end
        bus.tx_ready = (force_rdy < 0) ? ($urandom_range(0, 9) < 7) : force_rdy[0];
        #1;
        obs_la    = bus.line_active;
        obs_gid   = bus.grant_id;
        obs_tv    = bus.tx_valid;
        obs_td    = bus.tx_data;
        obs_ready = bus.req_ready;
        obs_acc   = bus.req_valid & bus.req_ready;
        obs_xfer  = bus.tx_valid & bus.tx_ready;
        step_no++;
        if (rst_n) begin
            exp_rdy = 4'b0000;
            if (obs_la && (!obs_tv || bus.tx_ready)) exp_rdy[obs_gid] = 1'b1;
            check("req_ready", obs_ready, exp_rdy);
            if (prev_hold) check("hold", {obs_tv, obs_td}, {1'b1, prev_td});
            if (prev_acc) check("load", {obs_tv, obs_td}, {1'b1, prev_byte});
            if (obs_la && !prev_la) begin
                line_own[n_lines] = obs_gid;
                line_len[n_lines] = 0;
                line_end[n_lines] = 0;
                n_lines++;
            end
            if (!obs_la && prev_la && n_lines > 0) line_end[n_lines-1] = step_no;
            prev_acc = 1'b0;
            for (int r = 0; r < 4; r++) begin
                if (obs_acc[r]) begin
                    d = bus.req_data[8*r +: 8];
                    if (n_lines > 0) line_len[n_lines-1]++;
                    check("accept", {1'b1, 2'(r), d},
                          (acc_idx < n_exp) ? {1'b1, eown[acc_idx], ebyte[acc_idx]} : 11'h0);
                    acc_idx++;
                    prev_acc  = 1'b1;
                    prev_byte = d;
                    last_acc_step[r] = step_no;
                    qhead[r]++;
                end
            end
            if (obs_xfer) begin
                check("xfer", {1'b1, obs_td}, (xfer_idx < n_exp) ? {1'b1, ebyte[xfer_idx]} : 9'h0);
                xfer_idx++;
            end
            prev_hold = obs_tv && !bus.tx_ready;
            prev_td   = obs_td;
        end else begin
            check("rst_ready", obs_ready, 4'b0000);
            prev_hold = 1'b0;
            prev_acc  = 1'b0;
        end
        prev_la = obs_la;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((pending() || obs_la || obs_tv) && n < 3000);
        check($sformatf("%s_drained", tag), {pending(), obs_la, obs_tv}, 3'b000);
        check($sformatf("%s_acc_count", tag), acc_idx, n_exp);
        check($sformatf("%s_xfer_count", tag), xfer_idx, n_exp);
    endtask

    task automatic check_lines(input string tag, input int n, input int own[4], input int len[4]);
        check($sformatf("%s_lines", tag), n_lines, n);
        for (int i = 0; i < n && i < 4; i++) begin
            check($sformatf("%s_owner%0d", tag, i), line_own[i], own[i]);
            if (len[i] > 0) check($sformatf("%s_len%0d", tag, i), line_len[i], len[i]);
        end
    endtask

    task automatic reset_model();
        new_test();
        mdl_last = 3;
        n_exp    = 0;
        acc_idx  = 0;
        xfer_idx = 0;
    endtask

    initial begin
        int own[4];
        int len[4];
        int ord5[5];
        logic [7:0] ab[4];
        int n, sel;
        logic [7:0] b;

        vectors     = 0;
        miscompares = 0;
        step_no     = 0;
        prev_hold   = 1'b0;
        prev_acc    = 1'b0;
        prev_la     = 1'b0;
        prev_td     = 8'h00;
        prev_byte   = 8'h00;
        bus.req_valid = 4'b0000;
        bus.req_data  = 32'h0;
        bus.tx_ready  = 1'b0;
        reset_model();

        // Reset values
        rst_n     = 1'b0;
        force_rdy = 1;
        @(negedge clk);
        step();
        step();
        check("rst_state", {bus.line_active, bus.grant_id, bus.tx_valid, bus.tx_data}, 12'h000);
        rst_n = 1'b1;

        // All four requesters busy: lines in order 0,1,2,3,0, each "X\n"
        new_test();
        force_rdy = -1;
        push_str(0, "X\nX\n");
        push_str(1, "X\n");
        push_str(2, "X\n");
        push_str(3, "X\n");
        build_expected();
        drain("order");
        ord5 = '{0, 1, 2, 3, 0};
        check("order_lines", n_lines, 5);
        for (int i = 0; i < 5; i++) begin
            check("order_owner", line_own[i], ord5[i]);
            check("order_len", line_len[i], 2);
        end

        // Requester 2 alone sends "AB\r\n" with tx_ready high
        new_test();
        force_rdy = 1;
        push_str(2, "AB\r\n");
        build_expected();
        step();
        step();
        check("ab_grant", {obs_la, obs_gid}, {1'b1, 2'd2});
        ab = '{8'h41, 8'h42, 8'h0D, 8'h0A};
        for (int i = 0; i < 4; i++) begin
            step();
            check("ab_seq", {obs_tv, obs_td}, {1'b1, ab[i]});
        end
        check("ab_release", obs_la, 1'b0);
        drain("ab");

        // Owner 1 streams 40 non-LF bytes; requester 2 waits with "Z\n"
        new_test();
        force_rdy = -1;
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            if (b == 8'h0A) b = 8'h0B;
            push(1, b);
        end
        push_str(2, "Z\n");
        build_expected();
        drain("maxline");
        own = '{1, 2, 1, 0};
        len = '{32, 2, 8, 0};
        check_lines("maxline", 3, own, len);

        // Transmitter stalled for 10 cycles with a byte loaded
        new_test();
        force_rdy = 0;
        push_str(0, "QR\n");
        build_expected();
        n = 0;
        do begin
            step();
            n++;
        end while (!obs_tv && n < 10);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            check("stall_data", {obs_tv, obs_td}, {1'b1, 8'h51});
            check("stall_ready", obs_ready[0], 1'b0);
        end
        force_rdy = 1;
        step();
        check("stall_xfer", {obs_xfer, obs_td}, {1'b1, 8'h51});
        drain("stall");

        // Owner 3 goes quiet mid-line; idle timeout hands over to requester 0
        new_test();
        force_rdy = 1;
        push_str(3, "ab");
        push_str(0, "Y\n");
        build_expected();
        drain("idle");
        own = '{3, 0, 0, 0};
        len = '{2, 2, 0, 0};
        check_lines("idle", 2, own, len);
        check("idle_release", line_end[0] - last_acc_step[3], IdleTo + 1);

        // Reset pulse mid-line while a byte sits in the output register
        new_test();
        force_rdy = 0;
        for (int i = 0; i < 20; i++) push(1, 8'h30 + 8'(i));
        build_expected();
        n = 0;
        do begin
            step();
            n++;
        end while (!obs_tv && n < 20);
        check("mid_loaded", obs_tv, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_mid", {bus.line_active, bus.grant_id, bus.tx_valid, bus.tx_data}, 12'h000);
        reset_model();
        force_rdy = -1;
        push_str(1, "K\n");
        push_str(0, "K\n");
        build_expected();
        drain("post_rst");
        own = '{0, 1, 0, 0};
        len = '{2, 2, 0, 0};
        check_lines("post_rst", 2, own, len);

        // Random traffic with random backpressure
        for (int seg = 0; seg < 8; seg++) begin
            new_test();
            force_rdy = -1;
            for (int r = 0; r < 4; r++) begin
                n = $urandom_range(0, 45);
                for (int i = 0; i < n; i++) begin
                    sel = $urandom_range(0, 15);
                    if (sel < 2) b = 8'h0A;
                    else if (sel == 2) b = 8'h0D;
                    else begin
                        b = 8'($urandom);
                        if (b == 8'h0A) b = 8'h0C;
                    end
                    push(r, b);
                end
            end
            build_expected();
            drain("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL expose parameter MAX_LINE, default 32, meaning the maximum number of bytes per granted line before a forced release.
REQ-002 The block SHALL expose parameter IDLE_TO, default 1024, meaning the number of consecutive owner-idle clock cycles before a forced release.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port req_valid  input  4  one byte-valid bit per requester 0..3.
REQ-006 The block SHALL have port req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-007 The block SHALL have port req_ready  output  4  requester i byte accepted when req_valid[i] and req_ready[i] are both high on a clk edge.
REQ-008 The block SHALL have port tx_valid  output  1  registered byte-valid to the shared UART transmitter.
REQ-009 The block SHALL have port tx_data  output  8  registered byte to the transmitter (LSB sent first by the transmitter, 8N1).
REQ-010 The block SHALL have port tx_ready  input  1  transmitter can take a byte; transfer when tx_valid and tx_ready are both high on a clk edge.
REQ-011 The block SHALL have port grant_id  output  2  index of the current line owner, meaningful only while line_active is high.
REQ-012 The block SHALL have port line_active  output  1  high while in state LOCK.

Function
REQ-013 The block SHALL implement two states: IDLE (no owner) and LOCK (one owner holds the transmitter for a whole line).
REQ-014 In IDLE with any req_valid bit high, the block SHALL grant the first requester with req_valid high, searching round-robin from (last_owner+1) mod 4, and enter LOCK on the next edge (one-cycle arbitration latency).
REQ-015 In IDLE, req_ready SHALL be 4'b0000.
REQ-016 In LOCK, req_ready SHALL be high only for bit grant_id, and only when (!tx_valid || tx_ready); all other bits SHALL be low (combinational).
REQ-017 On an accepted byte, tx_data SHALL load the owner's byte and tx_valid SHALL be set on the same edge; tx_data SHALL be held stable while tx_valid && !tx_ready.
REQ-018 tx_valid SHALL clear on a transmitter transfer edge unless a new byte is accepted on that same edge, in which case it SHALL remain high with the new data (back-to-back, one byte per cycle).
REQ-019 An 8-bit line counter SHALL reset to 0 on entering LOCK and increment on each accepted byte.
REQ-020 An accepted byte equal to 8'h0A (LF) SHALL end the line: the block SHALL return to IDLE on that edge.
REQ-021 A byte equal to 8'h0D (CR) SHALL be forwarded unchanged and SHALL NOT end the line.
REQ-022 The block SHALL return to IDLE on the edge that accepts the MAX_LINE-th byte of a line, even if that byte is not LF.
REQ-023 While in LOCK, an idle counter SHALL count consecutive cycles in which req_valid[grant_id] is low, clear on any cycle it is high, and force a return to IDLE when it reaches IDLE_TO.
REQ-024 On any return to IDLE, last_owner SHALL be updated to grant_id, and a byte already in the output register SHALL still be delivered.
REQ-025 A new arbitration SHALL proceed in IDLE while tx_valid is still high; the new owner's first byte SHALL wait for the output register to drain via REQ-016.
REQ-026 Requests from non-owners during LOCK SHALL be held off (ready low) and never dropped or reordered.
REQ-027 If LF and MAX_LINE coincide on the same byte, the block SHALL perform a single release.

Reset
REQ-028 While rst_n is low on a clk edge, the block SHALL set state=IDLE, tx_valid=0, tx_data=8'h00, grant_id=0, line_active=0, both counters=0, and last_owner=3 (so requester 0 has first priority).
REQ-029 A reset asserted mid-line SHALL discard any pending output byte; req_ready SHALL be 4'b0000 during and on the first cycle after reset.

Verification
REQ-030 The bench SHALL cover: requester 2 alone sends "AB\r\n" with tx_ready tied high -> grant_id=2 one cycle after req_valid, tx_data sequence 41,42,0D,0A on four consecutive cycles, IDLE after 0A.
REQ-031 The bench SHALL cover: all four requesters valid continuously, each sending "X\n" -> line order 0,1,2,3,0, with no interleaving within a line.
REQ-032 The bench SHALL cover: owner 1 streams 40 non-LF bytes with MAX_LINE=32 -> release after byte 32, requester 2 (valid) granted next, requester 1 resumes its 33rd byte only at its next turn.
REQ-033 The bench SHALL cover: tx_ready low for 10 cycles with a byte loaded -> tx_data stable, req_ready[owner]=0 throughout, transfer on the first tx_ready-high cycle.
REQ-034 The bench SHALL cover: owner stops mid-line with IDLE_TO=8 -> release exactly 8 cycles after its last valid, other requester granted.
REQ-035 The bench SHALL cover: rst_n pulsed low for one cycle mid-line with tx_valid=1 -> all outputs at reset values next cycle and requester 0 wins the next arbitration.
